dac_sample_sequencer: RTL and testbench

DAC_SAMPLE_SEQUENCER -- requirements
Module: dac_sample_sequencer

---
 rtl/dac_sample_sequencer_pkg.sv | 37 +++
 rtl/dac_sample_sequencer_tick.sv | 36 +++
 rtl/dac_sample_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_dac_sample_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dac_sample_sequencer_pkg.sv
// Shared definitions for the DAC sample sequencer.
//   - seq_state_e     : sequencer FSM state encoding
//   - CMD_WRITE_A     : command prefix, write input register A
//   - CMD_WRITE_B_UPD : command prefix, write input register B and update all
//   - DEF_INIT_WORD_* : default DAC configuration words sent after reset
//   - to_offset_binary: two's-complement sample -> DAC offset-binary code
package dac_sample_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_INIT0_SEND = 4'd0,
    ST_INIT0_WAIT = 4'd1,
    ST_INIT1_SEND = 4'd2,
    ST_INIT1_WAIT = 4'd3,
    ST_IDLE       = 4'd4,
    ST_SEND_A     = 4'd5,
    ST_WAIT_A     = 4'd6,
    ST_SEND_B     = 4'd7,
    ST_WAIT_B     = 4'd8
  } seq_state_e;

  localparam logic [7:0]  CMD_WRITE_A     = 8'h00;
  localparam logic [7:0]  CMD_WRITE_B_UPD = 8'h11;

  localparam logic [23:0] DEF_INIT_WORD_0 = 24'h380001;
  localparam logic [23:0] DEF_INIT_WORD_1 = 24'h300003;

  // Phase counter values shared by SEND_x and WAIT_x states.
  // SEND_x: phase 0 = waiting for ready, phases 1..2 = o_DAC_Send high.
  // WAIT_x: phases 0..1 = guard cycles, phase 2 = wait for ready.
  localparam logic [1:0]  SEND_LAST_PHASE  = 2'd2;
  localparam logic [1:0]  GUARD_LAST_PHASE = 2'd2;

  function automatic logic [15:0] to_offset_binary(input logic [15:0] sample);
    return {~sample[15], sample[14:0]};
  endfunction

endpackage

// File: rtl/dac_sample_sequencer_tick.sv
// dac_tick_gen: free-running divider producing the sample-period tick.
//   i_Clock : system clock
//   i_Reset : synchronous active-high reset, count returns to 0
//   o_tick  : high for one cycle while the count equals CLK_DIV-1
module dac_tick_gen #(
  parameter int unsigned CLK_DIV = 1000
) (
  input  logic i_Clock,
  input  logic i_Reset,
  output logic o_tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q + 1'b1;
    if (count_q == LAST_COUNT) begin
      count_d = '0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tick = (count_q == LAST_COUNT);

endmodule

// File: rtl/dac_sample_sequencer.sv
// dac_sample_sequencer: paces stereo samples into a 24-bit SPI DAC.
// After reset it sends two configuration words, then at every sample tick
// sends a channel-A word followed by a channel-B word (update all).
//   i_Clock, i_Reset        : clock, synchronous active-high reset
//   i_Sample_L/R, _Valid    : signed sample pair, captured on the valid strobe
//   i_DAC_Ready             : serialiser can accept a word
//   o_DAC_Data, o_DAC_Send  : word and send request to the serialiser
//   o_Sample_Request        : one-cycle pulse per tick asking for the next pair
//   o_Underrun / o_Overrun  : sticky error flags
//
// Serialiser handshake: a word is offered only once i_DAC_Ready has been seen
// high in the SEND state; o_DAC_Send is then held for exactly two cycles and
// o_DAC_Data stays constant from the first send cycle until the following
// WAIT state exits. WAIT spends two guard cycles before looking at ready again.
module dac_sample_sequencer
  import dac_sample_sequencer_pkg::*;
#(
  parameter int unsigned  CLK_DIV     = 1000,
  parameter logic [23:0]  INIT_WORD_0 = DEF_INIT_WORD_0,
  parameter logic [23:0]  INIT_WORD_1 = DEF_INIT_WORD_1
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [15:0] i_Sample_L,
  input  logic [15:0] i_Sample_R,
  input  logic        i_Sample_Valid,
  input  logic        i_DAC_Ready,
  output logic [23:0] o_DAC_Data,
  output logic        o_DAC_Send,
  output logic        o_Sample_Request,
  output logic        o_Underrun,
  output logic        o_Overrun
);

  logic tick;

  seq_state_e  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] work_q, work_d;
  logic        fresh_q, fresh_d;
  logic        underrun_q, underrun_d;
  logic        overrun_q, overrun_d;

  logic        start_seq;
  logic        in_init;
  logic        in_send;
  logic        in_wait;
  logic [23:0] state_word;

  dac_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .o_tick  (tick)
  );

  assign in_init = (state_q == ST_INIT0_SEND) || (state_q == ST_INIT0_WAIT) ||
                   (state_q == ST_INIT1_SEND) || (state_q == ST_INIT1_WAIT);
  assign in_send = (state_q == ST_INIT0_SEND) || (state_q == ST_INIT1_SEND) ||
                   (state_q == ST_SEND_A)     || (state_q == ST_SEND_B);
  assign in_wait = (state_q == ST_INIT0_WAIT) || (state_q == ST_INIT1_WAIT) ||
                   (state_q == ST_WAIT_A)     || (state_q == ST_WAIT_B);

  // Sample capture and tick handling. A tick is only acted on in IDLE; during
  // init it is ignored silently, elsewhere it is dropped and flagged.
  always_comb begin
    hold_d     = hold_q;
    fresh_d    = fresh_q;
    work_d     = work_q;
    underrun_d = underrun_q;
    overrun_d  = overrun_q;
    start_seq  = 1'b0;

    if (i_Sample_Valid) begin
      hold_d  = {i_Sample_L, i_Sample_R};
      fresh_d = 1'b1;
    end

    if (tick) begin
      if (state_q == ST_IDLE) begin
        start_seq = 1'b1;
        fresh_d   = 1'b0;
        // A pair arriving on the tick cycle itself is used directly.
        if (i_Sample_Valid) begin
          work_d = {i_Sample_L, i_Sample_R};
        end else begin
          work_d = hold_q;
          if (!fresh_q) begin
            underrun_d = 1'b1;
          end
        end
      end else if (!in_init) begin
        overrun_d = 1'b1;
      end
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;

    case (state_q)
      ST_INIT0_SEND, ST_INIT1_SEND, ST_SEND_A, ST_SEND_B: begin
        if (phase_q == 2'd0) begin
          if (i_DAC_Ready) begin
            phase_d = 2'd1;
          end
        end else if (phase_q == SEND_LAST_PHASE) begin
          phase_d = 2'd0;
          case (state_q)
            ST_INIT0_SEND: state_d = ST_INIT0_WAIT;
            ST_INIT1_SEND: state_d = ST_INIT1_WAIT;
            ST_SEND_A:     state_d = ST_WAIT_A;
            default:       state_d = ST_WAIT_B;
          endcase
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end

      ST_INIT0_WAIT, ST_INIT1_WAIT, ST_WAIT_A, ST_WAIT_B: begin
        if (phase_q != GUARD_LAST_PHASE) begin
          phase_d = phase_q + 2'd1;
        end else if (i_DAC_Ready) begin
          phase_d = 2'd0;
          case (state_q)
            ST_INIT0_WAIT: state_d = ST_INIT1_SEND;
            ST_WAIT_A:     state_d = ST_SEND_B;
            default:       state_d = ST_IDLE;
          endcase
        end
      end

      ST_IDLE: begin
        phase_d = 2'd0;
        if (start_seq) begin
          state_d = ST_SEND_A;
        end
      end

      default: begin
        state_d = ST_INIT0_SEND;
        phase_d = 2'd0;
      end
    endcase
  end

  // FSM: state register plus datapath registers
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= ST_INIT0_SEND;
      phase_q    <= 2'd0;
      hold_q     <= '0;
      work_q     <= '0;
      fresh_q    <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      work_q     <= work_d;
      fresh_q    <= fresh_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  // FSM: outputs. Everything is decoded from registers, so the cycle after
  // reset shows all outputs low even with i_DAC_Ready high.
  always_comb begin
    case (state_q)
      ST_INIT0_SEND, ST_INIT0_WAIT: state_word = INIT_WORD_0;
      ST_INIT1_SEND, ST_INIT1_WAIT: state_word = INIT_WORD_1;
      ST_SEND_A, ST_WAIT_A: state_word = {CMD_WRITE_A, to_offset_binary(work_q[31:16])};
      ST_SEND_B, ST_WAIT_B: state_word = {CMD_WRITE_B_UPD, to_offset_binary(work_q[15:0])};
      default:              state_word = '0;
    endcase

    o_DAC_Send = in_send && (phase_q != 2'd0);
    o_DAC_Data = (o_DAC_Send || in_wait) ? state_word : 24'h000000;
  end

  assign o_Sample_Request = tick;
  assign o_Underrun       = underrun_q;
  assign o_Overrun        = overrun_q;

endmodule

// File: tb/tb_dac_sample_sequencer.sv
module tb_dac_sample_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst100, rst64, ready100, ready64, valid;
  logic [15:0] samp_l, samp_r;

  logic [23:0] data100, data64;
  logic        send100, send64, req100, req64;
  logic        under100, under64, over100, over64;

  logic        sel;
  logic [23:0] cur_data;
  logic        cur_send, cur_req, cur_under, cur_over;

  assign cur_data  = sel ? data64  : data100;
  assign cur_send  = sel ? send64  : send100;
  assign cur_req   = sel ? req64   : req100;
  assign cur_under = sel ? under64 : under100;
  assign cur_over  = sel ? over64  : over100;

  int total = 0;
  int bad   = 0;

  dac_sample_sequencer #(.CLK_DIV(100)) u_dut100 (
    .i_Clock          (clk),
    .i_Reset          (rst100),
    .i_Sample_L       (samp_l),
    .i_Sample_R       (samp_r),
    .i_Sample_Valid   (valid),
    .i_DAC_Ready      (ready100),
    .o_DAC_Data       (data100),
    .o_DAC_Send       (send100),
    .o_Sample_Request (req100),
    .o_Underrun       (under100),
    .o_Overrun        (over100)
  );

  dac_sample_sequencer #(.CLK_DIV(64)) u_dut64 (
    .i_Clock          (clk),
    .i_Reset          (rst64),
    .i_Sample_L       (samp_l),
    .i_Sample_R       (samp_r),
    .i_Sample_Valid   (valid),
    .i_DAC_Ready      (ready64),
    .o_DAC_Data       (data64),
    .o_DAC_Send       (send64),
    .o_Sample_Request (req64),
    .o_Underrun       (under64),
    .o_Overrun        (over64)
  );

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_send"},  {23'd0, cur_send},  24'd0);
    chk({tag, "_data"},  cur_data,           24'd0);
    chk({tag, "_req"},   {23'd0, cur_req},   24'd0);
    chk({tag, "_under"}, {23'd0, cur_under}, 24'd0);
    chk({tag, "_over"},  {23'd0, cur_over},  24'd0);
  endtask

  // Waits (bounded) for the next send, then checks its word, its length,
  // its stability and that the word is still shown in the first WAIT cycle.
  task automatic check_word(input string tag, input logic [23:0] exp);
    int          waited = 0;
    int          len = 0;
    logic [23:0] first;
    bit          unstable = 1'b0;
    while (!cur_send && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_timeout"}, {23'd0, cur_send}, 24'd1);
    if (!cur_send) return;
    first = cur_data;
    while (cur_send && len < 8) begin
      if (cur_data !== first) unstable = 1'b1;
      len++;
      @(negedge clk);
    end
    chk({tag, "_word"},      first,                24'(exp));
    chk({tag, "_send_len"},  24'(len),             24'd2);
    chk({tag, "_stable"},    {23'd0, unstable},    24'd0);
    chk({tag, "_wait_hold"}, cur_data,             exp);
  endtask

  task automatic wait_req_high(input string tag);
    int waited = 0;
    while (!cur_req && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_req_seen"}, {23'd0, cur_req}, 24'd1);
  endtask

  initial begin
    int sends;
    sel = 1'b0; rst100 = 1'b1; rst64 = 1'b1;
    ready100 = 1'b1; ready64 = 1'b1; valid = 1'b0;
    samp_l = 16'h0000; samp_r = 16'h0000;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");

    // Init sequence after reset release
    rst100 = 1'b0;
    check_word("init0", 24'h380001);
    check_word("init1", 24'h300003);

    // First pair, captured well before the tick
    samp_l = 16'h0000; samp_r = 16'h7FFF; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; samp_l = 16'hDEAD; samp_r = 16'hBEEF;
    wait_req_high("tick1");
    @(negedge clk);
    chk("tick1_req_width", {23'd0, cur_req}, 24'd0);
    check_word("pair_a", 24'h008000);
    check_word("pair_b", 24'h11FFFF);
    chk("pair_under", {23'd0, cur_under}, 24'd0);
    chk("pair_over",  {23'd0, cur_over},  24'd0);

    // No new pair before the next tick: underrun and identical resend
    wait_req_high("tick2");
    @(negedge clk);
    check_word("resend_a", 24'h008000);
    check_word("resend_b", 24'h11FFFF);
    chk("resend_under", {23'd0, cur_under}, 24'd1);

    // Valid strobe on the tick cycle itself
    wait_req_high("tick3");
    samp_l = 16'h8000; samp_r = 16'h1234; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("tick3_req_width", {23'd0, cur_req}, 24'd0);
    check_word("coinc_a", 24'h000000);
    check_word("coinc_b", 24'h119234);
    chk("coinc_over", {23'd0, cur_over}, 24'd0);

    // Reset pulsed in WAIT_B
    samp_l = 16'h1111; samp_r = 16'h2222; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_req_high("tick4");
    @(negedge clk);
    check_word("rst_a", 24'h009111);
    check_word("rst_b", 24'h11A222);
    rst100 = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midreset");
    rst100 = 1'b0;
    check_word("reinit0", 24'h380001);
    check_word("reinit1", 24'h300003);

    // Overrun with the short divider: ready held low through a whole period
    sel = 1'b1; rst64 = 1'b0;
    check_word("d64_init0", 24'h380001);
    check_word("d64_init1", 24'h300003);
    samp_l = 16'h0100; samp_r = 16'hFF00; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_req_high("d64_tick1");
    ready64 = 1'b0;
    @(negedge clk);
    chk("d64_req_width", {23'd0, cur_req}, 24'd0);
    sends = 0;
    repeat (80) begin
      if (cur_send) sends++;
      @(negedge clk);
    end
    chk("d64_hold_no_send", 24'(sends), 24'd0);
    chk("d64_over_set", {23'd0, cur_over}, 24'd1);
    ready64 = 1'b1;
    check_word("d64_a", 24'h008100);
    check_word("d64_b", 24'h117F00);
    chk("d64_under", {23'd0, cur_under}, 24'd0);
    chk("d64_over_sticky", {23'd0, cur_over}, 24'd1);
    sends = 0;
    repeat (20) begin
      if (cur_send) sends++;
      @(negedge clk);
    end
    chk("d64_single_pair", 24'(sends), 24'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
